// File: rtl/conv_pkg.sv
// Shared types for the convolution output path: activation modes and the
// pack-writer FSM state encoding.
package conv_pkg;

    typedef enum logic [1:0] {
        PASS      = 2'd0,
        RELU      = 2'd1,
        RELU_CLIP = 2'd2,
        PASS2     = 2'd3
    } act_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/relu_clip.sv
// Per-byte activation: passthrough, ReLU, or ReLU clipped to an unsigned ceiling.
module relu_clip
    import conv_pkg::*;
(
    input  logic [7:0] x,
    input  act_mode_t  mode,
    input  logic [7:0] clip_max,
    output logic [7:0] y
);

    logic [7:0] relu;

    // After ReLU the value is non-negative, so an unsigned compare with the ceiling is exact
    assign relu = x[7] ? 8'd0 : x;

    always_comb begin
        y = x;
        case (mode)
            RELU:      y = relu;
            RELU_CLIP: y = (relu > clip_max) ? clip_max : relu;
            default:   y = x;
        endcase
    end

endmodule

// File: rtl/ofm_pack_writer.sv
// Accepts one activated NUM_CH-channel int8 pixel at a time and drains it as
// NUM_CH/4 consecutive 32-bit writes to the next-layer buffer.
module ofm_pack_writer
    import conv_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [15:0]           num_pixels,
    input  logic [1:0]            act_mode,
    input  logic [7:0]            clip_max,
    input  logic                  ofm_valid,
    input  logic [NUM_CH*8-1:0]   ofm_data,
    output logic                  ofm_ready,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam int NW  = NUM_CH / 4;
    localparam int WCW = (NW > 1) ? $clog2(NW) : 1;

    state_t              state_reg, state_next;
    logic [15:0]         pixel_cnt_reg;
    logic [15:0]         num_pixels_reg;
    logic [WCW-1:0]      word_cnt_reg;
    logic [ADDR_W-1:0]   addr_cnt_reg;
    logic [NUM_CH*8-1:0] buf_reg;
    logic [NUM_CH*8-1:0] act_bytes;
    act_mode_t           mode_reg;
    logic [7:0]          clip_reg;
    logic [31:0]         words [NW];
    logic                last_word;
    logic                last_pixel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_act
            relu_clip u_relu_clip (
                .x        (ofm_data[8*gi +: 8]),
                .mode     (mode_reg),
                .clip_max (clip_reg),
                .y        (act_bytes[8*gi +: 8])
            );
        end
        for (gi = 0; gi < NW; gi++) begin : g_word
            assign words[gi] = buf_reg[32*gi +: 32];
        end
    endgenerate

    assign last_word  = (word_cnt_reg == WCW'(NW - 1));
    assign last_pixel = ({1'b0, pixel_cnt_reg} + 17'd1) == {1'b0, num_pixels_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = (num_pixels == 16'd0) ? DONE : WAIT;
            WAIT:  if (ofm_valid) state_next = DRAIN;
            DRAIN: if (last_word) state_next = last_pixel ? DONE : WAIT;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Configuration is captured once per frame; start is ignored outside IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_cnt_reg  <= '0;
            num_pixels_reg <= '0;
            word_cnt_reg   <= '0;
            addr_cnt_reg   <= '0;
            buf_reg        <= '0;
            mode_reg       <= PASS;
            clip_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        num_pixels_reg <= num_pixels;
                        mode_reg       <= act_mode_t'(act_mode);
                        clip_reg       <= clip_max;
                        addr_cnt_reg   <= base_addr;
                        pixel_cnt_reg  <= '0;
                    end
                end
                WAIT: begin
                    if (ofm_valid) begin
                        buf_reg      <= act_bytes;
                        word_cnt_reg <= '0;
                    end
                end
                DRAIN: begin
                    addr_cnt_reg <= addr_cnt_reg + 1'b1;
                    if (last_word) begin
                        word_cnt_reg  <= '0;
                        pixel_cnt_reg <= pixel_cnt_reg + 16'd1;
                    end else begin
                        word_cnt_reg <= word_cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ofm_ready = (state_reg == WAIT);
    assign wr_en     = (state_reg == DRAIN);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign wr_addr   = addr_cnt_reg;
    assign wr_data   = wr_en ? words[word_cnt_reg] : 32'd0;

endmodule
